// File: rtl/mem_sram_ctrl.sv
// MEM-stage data-memory controller: each 32-bit access is split into two 16-bit SRAM phases.
// Define MEM_SRAM_PERF_CNT_EN to add the saturating rd_cnt/wr_cnt access counters.
module mem_sram_ctrl #(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        ALU_result,
  input  logic [31:0]        ST_val,
  output logic               ready,
  output logic [31:0]        rdata,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
`ifdef MEM_SRAM_PERF_CNT_EN
  ,
  output logic [15:0]        rd_cnt,
  output logic [15:0]        wr_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

  localparam int CW = $clog2(WAIT_CYCLES + 2);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [15:0]        dq_out_q, dq_out_d;
  logic               dq_oe_q, dq_oe_d;
  logic               we_n_q, we_n_d;
  logic               oe_n_q, oe_n_d;
  logic               req, wr, last_q, last_d;
  logic [31:0]        diff;
  logic [SRAM_AW-2:0] word_addr;
  logic               unused;

  assign req       = MEM_R_EN | MEM_W_EN;
  assign wr        = MEM_W_EN;
  assign last_q    = (cnt_q == LAST);
  assign last_d    = (cnt_d == LAST);
  assign diff      = ALU_result - ADDR_BASE;
  assign word_addr = diff[SRAM_AW:2];
  assign unused    = ^{diff[31:SRAM_AW+1], diff[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      dq_oe_q  <= dq_oe_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE: if (req) state_d = LO;
      LO: begin
        if (last_q) state_d = HI;
        else        cnt_d   = cnt_q + 1'b1;
      end
      HI: begin
        if (last_q) state_d = DONE;
        else        cnt_d   = cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM pins are registered, so they are decoded from the state being entered
  always_comb begin
    ready    = ((state_q == IDLE) && !req) || (state_q == DONE);
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    dq_oe_d  = 1'b0;
    we_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    rdata_d  = rdata_q;
    if (state_d == LO || state_d == HI) begin
      addr_d = {word_addr, state_d == HI};
      if (wr) begin
        dq_oe_d  = 1'b1;
        we_n_d   = last_d;
        dq_out_d = (state_d == HI) ? ST_val[31:16] : ST_val[15:0];
      end else begin
        oe_n_d = 1'b0;
      end
    end
    if (!wr && last_q) begin
      if (state_q == LO) rdata_d[15:0]  = sram_dq_in;
      if (state_q == HI) rdata_d[31:16] = sram_dq_in;
    end
  end

  assign rdata       = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;

`ifdef MEM_SRAM_PERF_CNT_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (state_q == DONE) begin
      if (wr) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: SRAM model plus scoreboards of expected bus writes and load data.
// A second instance with WAIT_CYCLES=0 covers the address-wrap case.
module tb_mem_sram_ctrl;

  typedef struct {
    logic [17:0] a;
    logic [15:0] d;
  } wexp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] alu_result, st_val;
  logic        ready;
  logic [31:0] rdata;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  logic        r2, w2;
  logic [31:0] a2, d2;
  logic        ready2;
  logic [31:0] rdata2;
  logic [17:0] sram_addr2;
  logic [15:0] dq_out2, dq_in2;
  logic        dq_oe2, we_n2, oe_n2;

`ifdef MEM_SRAM_PERF_CNT_EN
  logic [15:0] rd_cnt, wr_cnt, rd_cnt2, wr_cnt2;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  wexp_t       wq[$];
  logic [31:0] rq[$];

  logic [15:0] mem [0:63] = '{default: 16'h0};

  always @(posedge clk)
    if (!sram_we_n && sram_dq_oe) mem[sram_addr[5:0]] <= sram_dq_out;

  assign sram_dq_in = sram_oe_n ? 16'h0 : mem[sram_addr[5:0]];
  assign dq_in2     = oe_n2 ? 16'h0 : (sram_addr2[15:0] ^ 16'hA5A5);

  mem_sram_ctrl #(.ADDR_BASE(1024), .WAIT_CYCLES(1), .SRAM_AW(18)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(mem_r_en), .MEM_W_EN(mem_w_en),
    .ALU_result(alu_result), .ST_val(st_val), .ready(ready), .rdata(rdata),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
`ifdef MEM_SRAM_PERF_CNT_EN
    , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
`endif
  );

  mem_sram_ctrl #(.ADDR_BASE(1024), .WAIT_CYCLES(0), .SRAM_AW(18)) dut2 (
    .clk(clk), .rst(rst), .MEM_R_EN(r2), .MEM_W_EN(w2),
    .ALU_result(a2), .ST_val(d2), .ready(ready2), .rdata(rdata2),
    .sram_addr(sram_addr2), .sram_dq_out(dq_out2), .sram_dq_in(dq_in2),
    .sram_dq_oe(dq_oe2), .sram_we_n(we_n2), .sram_oe_n(oe_n2)
`ifdef MEM_SRAM_PERF_CNT_EN
    , .rd_cnt(rd_cnt2), .wr_cnt(wr_cnt2)
`endif
  );

  task automatic idle();
    @(posedge clk); #1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
  endtask

  task automatic access(input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        output int frz, output int welow, output int oelow);
    logic        prev_we;
    logic [31:0] exp_rd;
    wexp_t       e;
    @(posedge clk); #1;
    mem_r_en = r; mem_w_en = w; alu_result = a; st_val = d;
    frz = 0; welow = 0; oelow = 0; prev_we = 1'b1;
    @(negedge clk);
    while (!ready && frz < 40) begin
      frz++;
      if (!sram_we_n) welow++;
      if (!sram_oe_n) oelow++;
      if (!sram_we_n && prev_we) begin
        n_tests++;
        if (wq.size() == 0) begin
          n_fail++;
          $display("FAIL write_extra addr=%h dq=%h expected no write", sram_addr, sram_dq_out);
        end else begin
          e = wq.pop_front();
          if ({sram_addr, sram_dq_out, sram_dq_oe} !== {e.a, e.d, 1'b1}) begin
            n_fail++;
            $display("FAIL write_bus addr=%h dq=%h oe=%b expected addr=%h dq=%h oe=1",
                     sram_addr, sram_dq_out, sram_dq_oe, e.a, e.d);
          end
        end
      end
      prev_we = sram_we_n;
      @(negedge clk);
    end
    n_tests++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_timeout ready=%b expected 1 within 40 cycles", ready);
    end
    if (r && !w) begin
      n_tests++;
      if (rq.size() == 0) begin
        n_fail++;
        $display("FAIL load_extra rdata=%h expected no load", rdata);
      end else begin
        exp_rd = rq.pop_front();
        if (rdata !== exp_rd) begin
          n_fail++;
          $display("FAIL load_data rdata=%h expected %h", rdata, exp_rd);
        end
      end
    end
    n_tests++;
    if ({sram_we_n, sram_oe_n, sram_dq_oe} !== 3'b110) begin
      n_fail++;
      $display("FAIL done_ctrl we_n/oe_n/dq_oe=%b expected 110",
               {sram_we_n, sram_oe_n, sram_dq_oe});
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mem_r_en = 1'b0; mem_w_en = 1'b0; alu_result = '0; st_val = '0;
    r2 = 1'b0; w2 = 1'b0; a2 = '0; d2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({ready, sram_we_n, sram_oe_n, sram_dq_oe} !== 4'b1110) begin
      n_fail++;
      $display("FAIL reset_ctrl ready/we_n/oe_n/dq_oe=%b expected 1110",
               {ready, sram_we_n, sram_oe_n, sram_dq_oe});
    end
    n_tests++;
    if ({rdata, sram_addr, sram_dq_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_data rdata=%h addr=%h dq=%h expected all 0",
               rdata, sram_addr, sram_dq_out);
    end
    n_tests++;
    if ({ready2, rdata2} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_dut2 ready=%b rdata=%h expected 1 / 0", ready2, rdata2);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_store();
    int frz, wl, ol;
    wq.push_back('{a: 18'd2, d: 16'hBEEF});
    wq.push_back('{a: 18'd3, d: 16'hDEAD});
    access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, frz, wl, ol);
    idle();
    n_tests++;
    if ({frz, wl, ol} !== {32'd5, 32'd2, 32'd0}) begin
      n_fail++;
      $display("FAIL store_timing freeze=%0d we_low=%0d oe_low=%0d expected 5/2/0", frz, wl, ol);
    end
  endtask

  task automatic test_load();
    int frz, wl, ol;
    rq.push_back(32'hDEADBEEF);
    access(1'b1, 1'b0, 32'd1028, 32'h0, frz, wl, ol);
    idle();
    n_tests++;
    if ({frz, wl, ol} !== {32'd5, 32'd0, 32'd4}) begin
      n_fail++;
      $display("FAIL load_timing freeze=%0d we_low=%0d oe_low=%0d expected 5/0/4", frz, wl, ol);
    end
    @(negedge clk);
    n_tests++;
    if ({ready, rdata} !== {1'b1, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL load_hold ready=%b rdata=%h expected 1 / deadbeef", ready, rdata);
    end
  endtask

  task automatic test_both();
    int frz, wl, ol;
    wq.push_back('{a: 18'd0, d: 16'h5678});
    wq.push_back('{a: 18'd1, d: 16'h1234});
    access(1'b1, 1'b1, 32'd1024, 32'h12345678, frz, wl, ol);
    idle();
    n_tests++;
    if ({frz, wl, ol} !== {32'd5, 32'd2, 32'd0}) begin
      n_fail++;
      $display("FAIL both_timing freeze=%0d we_low=%0d oe_low=%0d expected 5/2/0", frz, wl, ol);
    end
    @(negedge clk);
    n_tests++;
    if (rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL both_rdata rdata=%h expected deadbeef", rdata);
    end
  endtask

  task automatic test_back_to_back();
    int frz1, frz2, wl, ol;
    rq.push_back(32'h12345678);
    wq.push_back('{a: 18'd4, d: 16'h0F0F});
    wq.push_back('{a: 18'd5, d: 16'hA5A5});
    access(1'b1, 1'b0, 32'd1024, 32'h0, frz1, wl, ol);
    access(1'b0, 1'b1, 32'd1032, 32'hA5A50F0F, frz2, wl, ol);
    idle();
    @(negedge clk);
    n_tests++;
    if ({frz1, frz2} !== {32'd5, 32'd5}) begin
      n_fail++;
      $display("FAIL b2b_freeze got %0d/%0d expected 5/5", frz1, frz2);
    end
    n_tests++;
    if ({mem[4], mem[5], 32'(wq.size()), 32'(rq.size())} !== {16'h0F0F, 16'hA5A5, 64'h0}) begin
      n_fail++;
      $display("FAIL b2b_mem mem4=%h mem5=%h wq=%0d rq=%0d expected 0f0f a5a5 0 0",
               mem[4], mem[5], wq.size(), rq.size());
    end
`ifdef MEM_SRAM_PERF_CNT_EN
    n_tests++;
    if ({rd_cnt, wr_cnt} !== {16'd2, 16'd3}) begin
      n_fail++;
      $display("FAIL perf_cnt rd=%0d wr=%0d expected 2/3", rd_cnt, wr_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int frz, wl, ol;
    @(posedge clk); #1;
    mem_w_en = 1'b1; alu_result = 32'd1032; st_val = 32'hCAFEF00D;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    mem_w_en = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({ready, sram_we_n, sram_oe_n, sram_dq_oe, rdata} !== {4'b1110, 32'h0}) begin
      n_fail++;
      $display("FAIL mid_reset ready/we_n/oe_n/dq_oe=%b rdata=%h expected 1110 / 0",
               {ready, sram_we_n, sram_oe_n, sram_dq_oe}, rdata);
    end
`ifdef MEM_SRAM_PERF_CNT_EN
    n_tests++;
    if ({rd_cnt, wr_cnt} !== 32'h0) begin
      n_fail++;
      $display("FAIL perf_reset rd=%0d wr=%0d expected 0/0", rd_cnt, wr_cnt);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    wq.push_back('{a: 18'd6, d: 16'h3344});
    wq.push_back('{a: 18'd7, d: 16'h1122});
    access(1'b0, 1'b1, 32'd1036, 32'h11223344, frz, wl, ol);
    idle();
    @(negedge clk);
    n_tests++;
    if ({frz, wl, mem[6], mem[7]} !== {32'd5, 32'd2, 16'h3344, 16'h1122}) begin
      n_fail++;
      $display("FAIL post_reset_store freeze=%0d we_low=%0d mem6=%h mem7=%h expected 5/2/3344/1122",
               frz, wl, mem[6], mem[7]);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] w, exp_rd;
    logic [17:0] lo, hi, seen_lo, seen_hi;
    int          frz, nseen;
    w      = (32'd1020 - 32'd1024) >> 2;
    lo     = {w[16:0], 1'b0};
    hi     = {w[16:0], 1'b1};
    exp_rd = {hi[15:0] ^ 16'hA5A5, lo[15:0] ^ 16'hA5A5};
    @(posedge clk); #1;
    r2 = 1'b1; a2 = 32'd1020;
    frz = 0; nseen = 0; seen_lo = '0; seen_hi = '0;
    @(negedge clk);
    while (!ready2 && frz < 40) begin
      frz++;
      if (!oe_n2) begin
        if (nseen == 0) seen_lo = sram_addr2;
        else            seen_hi = sram_addr2;
        nseen++;
      end
      @(negedge clk);
    end
    n_tests++;
    if ({frz, nseen} !== {32'd3, 32'd2}) begin
      n_fail++;
      $display("FAIL wrap_timing freeze=%0d read_cycles=%0d expected 3/2", frz, nseen);
    end
    n_tests++;
    if ({seen_lo, seen_hi} !== {lo, hi}) begin
      n_fail++;
      $display("FAIL wrap_addr lo=%h hi=%h expected %h/%h", seen_lo, seen_hi, lo, hi);
    end
    n_tests++;
    if (rdata2 !== exp_rd) begin
      n_fail++;
      $display("FAIL wrap_rdata rdata=%h expected %h", rdata2, exp_rd);
    end
    @(posedge clk); #1;
    r2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store();
    test_load();
    test_both();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
